// File: rtl/rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_pkg
// Purpose  : Shared types and helpers for the round-robin arbiter controller.
// Revision : 1.0 - initial release
// ============================================================================
package rr_arbiter_pkg;

  // Arbiter controller states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of a binary requester index; at least one bit even for tiny configs
  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_masked_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_masked_select
// Purpose  : Combinational rotating priority search. Finds the first set bit
//            of req scanning upward from ptr and wrapping past the top index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_masked_select
  import rr_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_W           = id_width(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic [ID_W-1:0]           ptr,
  output logic                      found,
  output logic [ID_W-1:0]           idx
);

  localparam int DW = $clog2(2 * NUM_REQUESTERS);

  // Doubling the vector turns the wrap-around search into a linear one
  logic [2*NUM_REQUESTERS-1:0] w_dbl;
  logic [DW-1:0]               w_pos;
  logic [DW-1:0]               w_wrap;

  assign w_dbl = {req, req};

  // Scan from the farthest offset down so the nearest hit to ptr wins last
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    w_pos  = '0;
    w_wrap = '0;
    for (int i = NUM_REQUESTERS - 1; i >= 0; i--) begin
      w_pos = DW'(ptr) + DW'(i);
      if (w_dbl[w_pos]) begin
        found  = 1'b1;
        w_wrap = (w_pos >= DW'(NUM_REQUESTERS)) ? (w_pos - DW'(NUM_REQUESTERS)) : w_pos;
        idx    = ID_W'(w_wrap);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_ctrl
// Purpose  : Round-robin arbiter sharing one downstream resource. Holds each
//            grant until release, request drop or hold timeout, and hands
//            over to the next requester with no idle cycle in between.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_ctrl
  import rr_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int MAX_HOLD       = 16,
  localparam int ID_W          = id_width(NUM_REQUESTERS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic                      release_grant,  // current grantee finished
  output logic [NUM_REQUESTERS-1:0] gnt,
  output logic [ID_W-1:0]           gnt_id,
  output logic                      gnt_valid,
  output logic                      timeout
);

  // Hold counter only needs to reach MAX_HOLD-1; keep one bit when disabled
  localparam int              HC_W        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0] c_hold_last = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;
  localparam logic [ID_W-1:0] c_last_id   = ID_W'(NUM_REQUESTERS - 1);

  arb_state_t                r_state;
  logic [ID_W-1:0]           r_ptr;
  logic [HC_W-1:0]           r_hold_cnt;

  logic                      w_cur_req;
  logic                      w_hit_release;
  logic                      w_hit_drop;
  logic                      w_hit_hold;
  logic                      w_end;
  logic [ID_W-1:0]           w_next_ptr;
  logic [NUM_REQUESTERS-1:0] w_sel_req;
  logic [ID_W-1:0]           w_sel_ptr;
  logic                      w_found;
  logic [ID_W-1:0]           w_sel_idx;

  assign w_cur_req     = req[gnt_id];
  assign w_hit_release = release_grant;
  assign w_hit_drop    = ~w_cur_req;
  assign w_hit_hold    = (MAX_HOLD > 0) && (r_hold_cnt == c_hold_last);
  assign w_end         = (r_state == GRANT) && (w_hit_release || w_hit_drop || w_hit_hold);
  assign w_next_ptr    = (gnt_id == c_last_id) ? '0 : (gnt_id + ID_W'(1));

  // While granted, search the others starting just past the grantee so the
  // handover winner is ready in the same cycle the tenure ends
  assign w_sel_req = (r_state == GRANT) ? (req & ~gnt) : req;
  assign w_sel_ptr = (r_state == GRANT) ? w_next_ptr : r_ptr;

  rr_masked_select #(
    .NUM_REQUESTERS (NUM_REQUESTERS),
    .ID_W           (ID_W)
  ) u_select (
    .req   (w_sel_req),
    .ptr   (w_sel_ptr),
    .found (w_found),
    .idx   (w_sel_idx)
  );

  // Grant FSM with registered grant, index, valid and timeout outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      gnt        <= '0;
      gnt_id     <= '0;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state    <= GRANT;
            gnt        <= NUM_REQUESTERS'(1) << w_sel_idx;
            gnt_id     <= w_sel_idx;
            gnt_valid  <= 1'b1;
            r_hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (w_end) begin
            r_ptr      <= w_next_ptr;
            r_hold_cnt <= '0;
            // Release or drop take precedence when reported alongside the hold limit
            timeout    <= w_hit_hold && !w_hit_release && !w_hit_drop;
            if (w_found) begin
              gnt    <= NUM_REQUESTERS'(1) << w_sel_idx;
              gnt_id <= w_sel_idx;
            end else if (w_cur_req && (w_hit_release || w_hit_hold)) begin
              // Sole remaining requester: start a fresh tenure for it
              gnt    <= gnt;
              gnt_id <= gnt_id;
            end else begin
              r_state   <= IDLE;
              gnt       <= '0;
              gnt_valid <= 1'b0;
            end
          end else if ((MAX_HOLD > 0) && (r_hold_cnt != c_hold_last)) begin
            r_hold_cnt <= r_hold_cnt + HC_W'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_ctrl
// Purpose  : Directed scoreboard bench for rr_arbiter_ctrl (N=4, MAX_HOLD=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_ctrl;

  localparam int N   = 4;
  localparam int MH  = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic           rel = 1'b0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           timeout;

  rr_arbiter_ctrl #(
    .NUM_REQUESTERS (N),
    .MAX_HOLD       (MH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .release_grant (rel),
    .gnt           (gnt),
    .gnt_id        (gnt_id),
    .gnt_valid     (gnt_valid),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]  cyc;
    logic [15:0]  tag;
    logic [N-1:0] gnt;
    logic         to;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   tag_cnt = 0;

  function automatic logic [IDW-1:0] exp_id(input logic [N-1:0] g);
    logic [IDW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = IDW'(i);
    return r;
  endfunction

  task automatic check_out(input int tag, input logic [N-1:0] eg, input logic eto);
    logic [IDW-1:0] eid;
    eid = exp_id(eg);
    n_vec++;
    if (gnt !== eg) begin
      n_bad++;
      $display("FAIL gnt v%0d: got %b expected %b", tag, gnt, eg);
    end
    if (gnt_valid !== (|eg)) begin
      n_bad++;
      $display("FAIL gnt_valid v%0d: got %b expected %b", tag, gnt_valid, |eg);
    end
    if (timeout !== eto) begin
      n_bad++;
      $display("FAIL timeout v%0d: got %b expected %b", tag, timeout, eto);
    end
    if ((|eg) && (gnt_id !== eid)) begin
      n_bad++;
      $display("FAIL gnt_id v%0d: got %0d expected %0d", tag, gnt_id, eid);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input logic [N-1:0] r, input logic rl,
                      input logic [N-1:0] eg, input logic eto);
    exp_t e;
    req   = r;
    rel   = rl;
    e.cyc = 32'(cyc + 1);
    e.tag = 16'(tag_cnt);
    e.gnt = eg;
    e.to  = eto;
    sb_q.push_back(e);
    tag_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation on the cycle it targets
  always @(negedge clk) begin
    while (sb_q.size() > 0 && int'(sb_q[0].cyc) <= cyc) begin
      mon_e = sb_q.pop_front();
      if (int'(mon_e.cyc) < cyc) begin
        n_bad++;
        $display("FAIL stale v%0d: checked at cycle %0d expected cycle %0d",
                 mon_e.tag, cyc, mon_e.cyc);
      end
      check_out(int'(mon_e.tag), mon_e.gnt, mon_e.to);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_out(900, '0, 1'b0);
    rst_n = 1'b1;

    // Idle with no requests
    repeat (10) step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // Basic latency and request drop (leaves ptr at 3)
    step(4'b0100, 1'b0, 4'b0100, 1'b0);
    step(4'b0100, 1'b0, 4'b0100, 1'b0);
    step(4'b0100, 1'b0, 4'b0100, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // Rotation with release every second grant cycle, starting from ptr=3
    step(4'b1111, 1'b0, 4'b1000, 1'b0);
    step(4'b1111, 1'b0, 4'b1000, 1'b0);
    step(4'b1111, 1'b1, 4'b0001, 1'b0);
    step(4'b1111, 1'b0, 4'b0001, 1'b0);
    step(4'b1111, 1'b1, 4'b0010, 1'b0);
    step(4'b1111, 1'b0, 4'b0010, 1'b0);
    step(4'b1111, 1'b1, 4'b0100, 1'b0);
    step(4'b1111, 1'b0, 4'b0100, 1'b0);
    step(4'b1111, 1'b1, 4'b1000, 1'b0);
    step(4'b1111, 1'b0, 4'b1000, 1'b0);
    step(4'b1111, 1'b1, 4'b0001, 1'b0);

    // Hold timeout ping-pong between requesters 0 and 1
    repeat (3) step(4'b0011, 1'b0, 4'b0001, 1'b0);
    step(4'b0011, 1'b0, 4'b0010, 1'b1);
    repeat (3) step(4'b0011, 1'b0, 4'b0010, 1'b0);
    step(4'b0011, 1'b0, 4'b0001, 1'b1);

    // Sole requester: drop of 0 hands to 3, then timeouts re-grant 3
    step(4'b1000, 1'b0, 4'b1000, 1'b0);
    repeat (2) begin
      repeat (3) step(4'b1000, 1'b0, 4'b1000, 1'b0);
      step(4'b1000, 1'b0, 4'b1000, 1'b1);
    end

    // Release coinciding with hold limit reports no timeout
    step(4'b0101, 1'b0, 4'b0001, 1'b0);
    repeat (3) step(4'b0101, 1'b0, 4'b0001, 1'b0);
    step(4'b0101, 1'b1, 4'b0100, 1'b0);

    // Other request bits toggling do not disturb the grant; release re-grants sole requester
    step(4'b0110, 1'b0, 4'b0100, 1'b0);
    step(4'b1100, 1'b0, 4'b0100, 1'b0);
    step(4'b0100, 1'b1, 4'b0100, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 1'b0);

    // Asynchronous reset while granted
    step(4'b0010, 1'b0, 4'b0010, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_out(901, '0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = '0;
    rel   = 1'b0;
    step(4'b0000, 1'b0, 4'b0000, 1'b0);
    step(4'b1111, 1'b0, 4'b0001, 1'b0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_ctrl.md
Name: rr_arbiter_ctrl

Overview:
- Round-robin arbiter/controller that shares one downstream resource among NUM_REQUESTERS requesters.
- Grants at most one requester at a time and holds the grant until release, request drop or hold timeout.
- Re-arbitrates with zero bubble cycles.
- Selection uses a masked priority search; sits between requester blocks and the shared datapath mux select.

Parameters:
- NUM_REQUESTERS, 4, number of requesters; legal range 2..32.
- MAX_HOLD, 16, max consecutive grant cycles per tenure; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQUESTERS  request vector; bit i high means requester i wants the resource.
- release  input  1  current grantee finished; ignored when gnt_valid=0.
- gnt  output  NUM_REQUESTERS  one-hot grant, or all-zero.
- gnt_id  output  ID_W  binary index of the grantee; ID_W = max(1, $clog2(NUM_REQUESTERS)).
- gnt_valid  output  1  high when gnt is non-zero.
- timeout  output  1  one-cycle pulse when a grant is force-ended by MAX_HOLD.

Behaviour:
- Clock, reset and outputs:
  - One clock domain.
  - Reset is asynchronous, active-low (rst_n).
  - All outputs are registered.
- Reset values: gnt='0, gnt_id='0, gnt_valid=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
- Reset asserted mid-tenure clears the grant immediately (asynchronously). No timeout pulse is generated.
- Selection function sel(mask_req, ptr): first set bit of mask_req scanning ascending from index ptr, wrapping past NUM_REQUESTERS-1 to 0. Returns found flag plus index.
- FSM states IDLE, GRANT.
  - IDLE: if req!=0, next cycle enter GRANT with grantee = sel(req, ptr). Latency from req high to gnt high is 1 cycle. Otherwise stay IDLE.
  - GRANT: the tenure ends on the cycle any of these is sampled:
    - (a) release=1
    - (b) req[gnt_id]=0
    - (c) MAX_HOLD>0 and hold_cnt==MAX_HOLD-1
  - On tenure end:
    - ptr <= (gnt_id+1) mod NUM_REQUESTERS.
    - Candidate set is req with bit gnt_id cleared.
    - If the candidate set is non-zero, grant the next winner on the following cycle (back-to-back, no idle cycle) and stay in GRANT.
    - Else if req[gnt_id] is still 1 and the end cause was (a) or (c), re-grant the same requester (sole requester).
    - Else go to IDLE with gnt cleared.
  - No tenure end: grant unchanged; hold_cnt increments.
- hold_cnt:
  - Reset to 0 at each new grant.
  - Width $clog2(MAX_HOLD+1); saturates at MAX_HOLD-1 (never wraps).
  - Unused when MAX_HOLD=0.
- timeout: asserted the cycle after the tenure end if and only if cause (c) ended it and neither (a) nor (b) was also true. Simultaneous causes report as release, not timeout.
- Simultaneous events:
  - release in the same cycle as a new req from another requester: the new requester is eligible immediately.
  - req changes in other bits during a tenure do not disturb the current grant.
- Invariants:
  - gnt==(1<<gnt_id) whenever gnt_valid=1.
  - gnt_valid==|gnt.
  - A requester holding req high continuously is granted within NUM_REQUESTERS-1 tenures (no starvation).

Decomposition:
- Package rr_arbiter_pkg holds:
  - the state enum type (IDLE, GRANT)
  - function id_width(n) returning max(1, $clog2(n))
- One sub-module, rr_masked_select, is natural:
  - combinational; takes req and ptr
  - returns found plus index via a doubled-vector (req concatenated with itself) priority scan from ptr
  - parameterized by NUM_REQUESTERS

Test Plan:
- Reset/idle: rst_n=0 then 1 with req=0 for 10 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout. Assert rst_n low while granted -> gnt cleared without waiting for a clock edge.
- Basic latency (N=4): req=4'b0100 at cycle t -> gnt=4'b0100, gnt_id=2 at t+1. Drop req[2] at t+3 -> gnt=0 at t+4. ptr=3.
- Round-robin rotation: req=4'b1111 held, release pulsed every 2 grant cycles -> grant order 0,1,2,3,0 with no idle cycle between tenures.
- Timeout (MAX_HOLD=4): req=4'b0011, no release -> requester 0 granted 4 cycles, timeout=1 for one cycle as gnt switches to 4'b0010. Requester 1 gets 4 cycles, then back to 0.
- Sole requester timeout: req=4'b1000 only, MAX_HOLD=4 -> timeout pulses every 4 cycles, gnt stays 4'b1000 continuously.
- Simultaneous causes: release=1 on the same cycle hold_cnt hits MAX_HOLD-1, req=4'b0101 -> timeout stays 0, grant moves from 0 to 2 next cycle.
